// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, next-PC select encoding and fetch sequencer states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        IFETCH  = 2'd0,
        DACCESS = 2'd1,
        HALTED  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_request_if.sv
// Bundle of the fetch request unit's signals; fru is the unit's view, tb drives the control side.
interface fetch_request_if;
    import cpu_types_pkg::*;

    logic        ihit;
    logic        dhit;
    logic        dREN;
    logic        dWEN;
    logic        halt;
    logic [1:0]  PCsrc;
    logic        branch_taken;
    logic [15:0] imm;
    logic [25:0] addr;
    word_t       jr_target;
    word_t       pc;
    logic        imemREN;
    logic        dmemREN;
    logic        dmemWEN;
    logic        reg_commit;
    logic        halted;
    word_t       cyc_count;
    word_t       instr_count;

    modport fru (
        input  ihit, dhit, dREN, dWEN, halt, PCsrc, branch_taken, imm, addr, jr_target,
        output pc, imemREN, dmemREN, dmemWEN, reg_commit, halted, cyc_count, instr_count
    );

    modport tb (
        output ihit, dhit, dREN, dWEN, halt, PCsrc, branch_taken, imm, addr, jr_target,
        input  pc, imemREN, dmemREN, dmemWEN, reg_commit, halted, cyc_count, instr_count
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, conditional branch, J-type jump, register jump.
module next_pc_calc
    import cpu_types_pkg::*;
(
    input  word_t       pc,
    input  pcsrc_t      pcsrc,
    input  logic        branch_taken,
    input  logic [15:0] imm,
    input  logic [25:0] addr,
    input  word_t       jr_target,
    output word_t       next_pc
);

    word_t pc4;
    word_t branch_off;

    always_comb begin
        pc4        = pc + 32'd4;
        branch_off = {{14{imm[15]}}, imm, 2'b00};
        next_pc    = pc4;
        case (pcsrc)
            PC_NEXT:   next_pc = pc4;
            PC_BRANCH: next_pc = branch_taken ? (pc4 + branch_off) : pc4;
            PC_JUMP:   next_pc = (pc4 & 32'hF000_0000) | {4'b0000, addr, 2'b00};
            PC_JR:     next_pc = jr_target;
            default:   next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/fetch_request_unit.sv
// PC owner and fetch/data-access sequencer for the single-cycle datapath.
// Optional cycle/retire counters are built when FETCH_PERF_COUNTERS_EN is defined.
module fetch_request_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic              halt,
    input  logic [1:0]        PCsrc,
    input  logic              branch_taken,
    input  logic [15:0]       imm,
    input  logic [25:0]       addr,
    input  logic [WORD_W-1:0] jr_target,
    output logic [WORD_W-1:0] pc,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              reg_commit,
    output logic              halted,
    output logic [WORD_W-1:0] cyc_count,
    output logic [WORD_W-1:0] instr_count
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        next_pc;
    logic         halt_entry;

    next_pc_calc u_next_pc (
        .pc           (pc_q),
        .pcsrc        (pcsrc_t'(PCsrc)),
        .branch_taken (branch_taken),
        .imm          (imm),
        .addr         (addr),
        .jr_target    (jr_target),
        .next_pc      (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        imemREN    = 1'b0;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        reg_commit = 1'b0;
        halted     = 1'b0;
        halt_entry = 1'b0;
        case (state_q)
            IFETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    if (halt) begin
                        state_d    = HALTED;
                        halt_entry = 1'b1;
                    end else if (dREN || dWEN) begin
                        state_d = DACCESS;
                    end else begin
                        reg_commit = 1'b1;
                        pc_d       = next_pc;
                    end
                end
            end
            DACCESS: begin
                // Instruction word is held by memory, so requests follow the decode live.
                dmemREN = dREN;
                dmemWEN = dWEN;
                if (dhit) begin
                    reg_commit = 1'b1;
                    pc_d       = next_pc;
                    state_d    = IFETCH;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = IFETCH;
            end
        endcase
        if (RST) begin
            imemREN    = 1'b0;
            dmemREN    = 1'b0;
            dmemWEN    = 1'b0;
            reg_commit = 1'b0;
            halt_entry = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IFETCH;
            pc_q    <= PC_INIT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc = pc_q;

`ifdef FETCH_PERF_COUNTERS_EN
    word_t cyc_q, cyc_d;
    word_t instr_q, instr_d;

    always_comb begin
        cyc_d   = (state_q == HALTED) ? cyc_q : cyc_q + 32'd1;
        instr_d = (reg_commit || halt_entry) ? instr_q + 32'd1 : instr_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cyc_q   <= '0;
            instr_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            instr_q <= instr_d;
        end
    end

    assign cyc_count   = cyc_q;
    assign instr_count = instr_q;
`else
    assign cyc_count   = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_fetch_request_unit.sv
// Bench for fetch_request_unit: directed fetch/branch/jump/load/halt scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_fetch_request_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, dREN, dWEN, halt, branch_taken;
    logic [1:0]  PCsrc;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [31:0] jr_target;
    logic [31:0] pc, cyc_count, instr_count;
    logic        imemREN, dmemREN, dmemWEN, reg_commit, halted;

    always #5 CLK = ~CLK;

    fetch_request_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
        .halt(halt), .PCsrc(PCsrc), .branch_taken(branch_taken), .imm(imm), .addr(addr),
        .jr_target(jr_target), .pc(pc), .imemREN(imemREN), .dmemREN(dmemREN),
        .dmemWEN(dmemWEN), .reg_commit(reg_commit), .halted(halted),
        .cyc_count(cyc_count), .instr_count(instr_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural PC, "instruction waiting on data memory", halted flag, tallies.
    logic [31:0] m_pc;
    bit          m_wait_data;
    bit          m_halted;
    int unsigned m_cycles, m_retired, m_halts;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [1:0] src,
                                                input bit taken, input logic [15:0] im,
                                                input logic [25:0] ad, input logic [31:0] jr);
        logic [31:0] seq;
        logic [31:0] offset;
        seq    = cur + 32'd4;
        offset = {{16{im[15]}}, im};
        case (src)
            2'd0:    return seq;
            2'd1:    return taken ? seq + offset * 32'd4 : seq;
            2'd2:    return (seq & 32'hF000_0000) | (32'(ad) * 32'd4);
            default: return jr;
        endcase
    endfunction

    task automatic model_reset();
        m_pc        = 32'h0;
        m_wait_data = 0;
        m_halted    = 0;
        m_cycles    = 0;
        m_retired   = 0;
        m_halts     = 0;
    endtask

    function automatic bit exp_commit();
        if (m_halted) return 0;
        if (m_wait_data) return dhit;
        return ihit && !halt && !(dREN || dWEN);
    endfunction

    task automatic check_outputs();
        check("pc", pc, m_pc);
        check("imemREN", 32'(imemREN), 32'(!m_wait_data && !m_halted));
        check("dmemREN", 32'(dmemREN), 32'(m_wait_data && dREN));
        check("dmemWEN", 32'(dmemWEN), 32'(m_wait_data && dWEN));
        check("reg_commit", 32'(reg_commit), 32'(exp_commit()));
        check("halted", 32'(halted), 32'(m_halted));
`ifdef FETCH_PERF_COUNTERS_EN
        check("cyc_count", cyc_count, m_cycles);
        check("instr_count", instr_count, m_retired + m_halts);
`else
        check("cyc_count", cyc_count, 32'h0);
        check("instr_count", instr_count, 32'h0);
`endif
    endtask

    // One cycle: drive on the falling edge, check mid-cycle, advance the model on the rising edge.
    task automatic step(input bit i_ihit, input bit i_dhit, input bit i_dren, input bit i_dwen,
                        input bit i_halt, input logic [1:0] src, input bit taken,
                        input logic [15:0] im, input logic [25:0] ad, input logic [31:0] jr);
        bit          commit;
        logic [31:0] npc;
        @(negedge CLK);
        ihit = i_ihit; dhit = i_dhit; dREN = i_dren; dWEN = i_dwen; halt = i_halt;
        PCsrc = src; branch_taken = taken; imm = im; addr = ad; jr_target = jr;
        #1;
        check_outputs();
        commit = exp_commit();
        npc    = ref_next_pc(m_pc, src, taken, im, ad, jr);
        @(posedge CLK);
        if (!m_halted) m_cycles++;
        if (commit) begin
            m_pc        = npc;
            m_wait_data = 0;
            m_retired++;
        end else if (!m_halted && !m_wait_data && i_ihit) begin
            if (i_halt) begin
                m_halted = 1;
                m_halts++;
            end else begin
                m_wait_data = 1;
            end
        end
    endtask

    task automatic expect_pc(input string tag, input logic [31:0] exp);
        #1;
        check(tag, pc, exp);
    endtask

    task automatic alu_op(input logic [1:0] src, input bit taken, input logic [15:0] im,
                          input logic [25:0] ad, input logic [31:0] jr);
        step(1, 0, 0, 0, 0, src, taken, im, ad, jr);
    endtask

    logic [31:0] cyc_at_halt;

    initial begin
        RST = 1; ihit = 0; dhit = 0; dREN = 0; dWEN = 0; halt = 0;
        PCsrc = 2'd0; branch_taken = 0; imm = '0; addr = '0; jr_target = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_imemREN", 32'(imemREN), 32'h0);
        check("rst_dmem", 32'({dmemREN, dmemWEN}), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        @(negedge CLK);
        RST = 0;
        #1;
        check("post_rst_imemREN", 32'(imemREN), 32'h1);

        // Sequential fetch, then branches, jump and register jump from chosen PCs.
        alu_op(2'd0, 0, 16'h0, 26'h0, 32'h0);
        expect_pc("seq_pc", 32'h4);
        alu_op(2'd3, 0, 16'h0, 26'h0, 32'h10);
        expect_pc("jr_to_10", 32'h10);
        alu_op(2'd1, 1, 16'hFFFF, 26'h0, 32'h0);
        expect_pc("branch_taken_back", 32'h10);
        alu_op(2'd1, 0, 16'hFFFF, 26'h0, 32'h0);
        expect_pc("branch_not_taken", 32'h14);
        alu_op(2'd3, 0, 16'h0, 26'h0, 32'h4000_0000);
        alu_op(2'd2, 0, 16'h0, 26'h0000100, 32'h0);
        expect_pc("jump", 32'h4000_0400);
        alu_op(2'd3, 0, 16'h0, 26'h0, 32'h0000_0ABC);
        expect_pc("jr_unaligned", 32'h0000_0ABC);

        // Load: enters data access, three waits with a stray ihit, then dhit retires it.
        step(1, 0, 1, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        expect_pc("load_pc_held", 32'h0000_0ABC);
        repeat (3) step(1, 0, 1, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        expect_pc("load_wait_pc", 32'h0000_0ABC);
        step(0, 1, 1, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        expect_pc("load_done_pc", 32'h0000_0AC0);
        step(0, 0, 0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);

        // Random traffic with occasional loads, stores and illegal load+store.
        for (int i = 0; i < 400; i++) begin
            int  kind;
            bit  r, w;
            kind = $urandom_range(0, 9);
            r = (kind == 0) || (kind == 2);
            w = (kind == 1) || (kind == 2);
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0), r, w, 0,
                 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 16'($urandom),
                 26'($urandom), $urandom);
        end

        // Reset asserted mid data access drops requests immediately.
        alu_op(2'd3, 0, 16'h0, 26'h0, 32'h100);
        step(1, 0, 0, 1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        @(negedge CLK);
        dWEN = 1; dREN = 1; dhit = 0; ihit = 0;
        #1;
        check("pre_rst_dmemWEN", 32'(dmemWEN), 32'h1);
        RST = 1;
        #1;
        check("mid_rst_dmem", 32'({dmemREN, dmemWEN}), 32'h0);
        check("mid_rst_pc", pc, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 0; dREN = 0; dWEN = 0;
        model_reset();

        // Halt at 0x20, then stay frozen.
        alu_op(2'd3, 0, 16'h0, 26'h0, 32'h20);
        alu_op(2'd0, 0, 16'h0, 26'h0, 32'h0);
        alu_op(2'd3, 0, 16'h0, 26'h0, 32'h20);
        step(1, 0, 0, 0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        #1;
        cyc_at_halt = cyc_count;
        for (int i = 0; i < 10; i++)
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, 0, 0,
                 2'd0, 0, 16'h0, 26'h0, 32'h0);
        #1;
        check("halt_pc", pc, 32'h20);
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_cyc_frozen", cyc_count, cyc_at_halt);
`ifdef FETCH_PERF_COUNTERS_EN
        check("halt_instr_count", instr_count, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
